dmem_arbiter: RTL and testbench

//  Shares the single-port 512-word data memory between the pipeline MEM stage (CPU port)
//  and a debug/dump port (bench memory dump, loader). Grants one access per cycle,

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between MEM stage and debug port.
// CPU priority with debug starvation guard, halt mode and fixed-latency read return.
module dmem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_halt,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    RUN,
    FORCE,
    HALT
  } arbState_e;

  arbState_e        state, stateNxt;
  logic [CNT_W-1:0] waitCnt, waitCntNxt;
  logic             cpuGnt, dbgGnt;
  logic             cpuRdPend, dbgRdPend;

  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    cpuGnt     = 1'b0;
    dbgGnt     = 1'b0;
    unique case (state)
      RUN: begin
        cpuGnt = cpu_req & ~dbg_halt;
        dbgGnt = dbg_req & ~cpuGnt;
        if (!dbg_req || dbgGnt) begin
          waitCntNxt = '0;
        end else if (waitCnt == CNT_MAX) begin
          stateNxt = FORCE;
        end else begin
          waitCntNxt = waitCnt + 1'b1;
        end
      end
      // One debug grant (or a withdrawn request) ends the forced window
      FORCE: begin
        dbgGnt     = dbg_req;
        cpuGnt     = cpu_req & ~dbg_req & ~dbg_halt;
        stateNxt   = RUN;
        waitCntNxt = '0;
      end
      HALT: begin
        dbgGnt     = dbg_req;
        stateNxt   = RUN;
        waitCntNxt = '0;
      end
      default: begin
        stateNxt   = RUN;
        waitCntNxt = '0;
      end
    endcase
    if (dbg_halt) stateNxt = HALT;
  end

  assign cpu_stall = cpu_req & ~cpuGnt;
  assign dbg_gnt   = dbgGnt;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      waitCnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpuRdPend  <= 1'b0;
      dbgRdPend  <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      mem_en  <= cpuGnt | dbgGnt;
      mem_we  <= (cpuGnt & cpu_we) | (dbgGnt & dbg_we);
      if (cpuGnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (dbgGnt) begin
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
      end
      // Owner tag travels with each read so data returns to its port
      cpuRdPend  <= cpuGnt & ~cpu_we;
      dbgRdPend  <= dbgGnt & ~dbg_we;
      cpu_rvalid <= cpuRdPend;
      dbg_rvalid <= dbgRdPend;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with a
// synchronous 512-word memory model attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        dbg_halt = 1'b0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] memArr [512];
  logic [31:0] expMem [512];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(9),
    .DATA_W(32),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .dbg_halt(dbg_halt),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) memArr[mem_addr] <= mem_wdata;
      else        mem_rdata <= memArr[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 512; i++) begin
      memArr[i] = 32'hA500_0000 | 32'(i);
      expMem[i] = 32'hA500_0000 | 32'(i);
    end
    memArr[5] = 32'hDEAD_BEEF;
    expMem[5] = 32'hDEAD_BEEF;

    tick();
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);

    // 1: single CPU read
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd5;
    #1;
    chk("t1_stall", cpu_stall, 0);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 5);
    tick();
    #1;
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_dbg_rvalid", dbg_rvalid, 0);
    tick();
    #1;
    chk("t1_idle_en", mem_en, 0);
    chk("t1_rvalid_off", cpu_rvalid, 0);

    // 2: starvation guard forces debug through on 5th cycle
    cpu_req = 1'b1; cpu_addr = 9'd10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'd7;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("t2_stall_c%0d", c), cpu_stall, (c == 5) ? 1 : 0);
      chk($sformatf("t2_gnt_c%0d", c), dbg_gnt, (c == 5) ? 1 : 0);
      tick();
    end
    dbg_req = 1'b0;
    #1;
    chk("t2_stall_after", cpu_stall, 0);
    chk("t2_cpu_rvalid", cpu_rvalid, 1);
    chk("t2_cpu_rdata", cpu_rdata, expMem[10]);
    tick();
    cpu_req = 1'b0;
    #1;
    chk("t2_dbg_rvalid", dbg_rvalid, 1);
    chk("t2_dbg_rdata", dbg_rdata, expMem[7]);
    chk("t2_cpu_rvalid_off", cpu_rvalid, 0);
    tick();
    tick();

    // 3: halt mode, full memory dump
    dbg_halt = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_addr = 9'd0;
    pulses = 0;
    for (int i = 0; i < 514; i++) begin
      dbg_req  = (i < 512);
      dbg_addr = 9'(i);
      #1;
      chk($sformatf("t3_stall_%0d", i), cpu_stall, 1);
      chk($sformatf("t3_cpu_rvalid_%0d", i), cpu_rvalid, 0);
      if (i < 512) chk($sformatf("t3_gnt_%0d", i), dbg_gnt, 1);
      if (i >= 2) begin
        chk($sformatf("t3_rvalid_%0d", i - 2), dbg_rvalid, 1);
        chk($sformatf("t3_rdata_%0d", i - 2), dbg_rdata, expMem[i-2]);
      end
      if (dbg_rvalid) pulses++;
      tick();
    end
    chk("t3_pulses", 32'(pulses), 512);
    dbg_halt = 1'b0; dbg_req = 1'b0; cpu_req = 1'b0;
    tick();
    tick();

    // 4: same-address conflict, CPU write first
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd3; cpu_wdata = 32'h11;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'd3;
    #1;
    chk("t4_cpu_first", cpu_stall, 0);
    chk("t4_dbg_wait", dbg_gnt, 0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    expMem[3] = 32'h11;
    #1;
    chk("t4_dbg_gnt", dbg_gnt, 1);
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_wdata", mem_wdata, 32'h11);
    tick();
    dbg_req = 1'b0;
    #1;
    chk("t4_rd_cmd_we", mem_we, 0);
    chk("t4_rd_cmd_addr", mem_addr, 3);
    chk("t4_no_cpu_rvalid", cpu_rvalid, 0);
    tick();
    #1;
    chk("t4_dbg_rvalid", dbg_rvalid, 1);
    chk("t4_dbg_rdata", dbg_rdata, expMem[3]);
    tick();

    // 6: alternating CPU/debug reads
    for (int i = 0; i < 10; i++) begin
      cpu_req  = (i < 8) && (i % 2 == 0);
      dbg_req  = (i < 8) && (i % 2 == 1);
      cpu_addr = 9'(40 + i);
      dbg_addr = 9'(40 + i);
      #1;
      chk($sformatf("t6_stall_%0d", i), cpu_stall, 0);
      chk($sformatf("t6_gnt_%0d", i), dbg_gnt,
          ((i < 8) && (i % 2 == 1)) ? 1 : 0);
      if (i >= 2) begin
        chk($sformatf("t6_cpu_rv_%0d", i), cpu_rvalid,
            (i % 2 == 0) ? 1 : 0);
        chk($sformatf("t6_dbg_rv_%0d", i), dbg_rvalid,
            (i % 2 == 1) ? 1 : 0);
        chk($sformatf("t6_rdata_%0d", i), mem_rdata, expMem[40+i-2]);
      end
      tick();
    end
    tick();

    // 5: reset one cycle after a CPU read accept
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd9;
    tick();
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_async_en", mem_en, 0);
    chk("t5_async_addr", mem_addr, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_cpu_rvalid_%0d", i), cpu_rvalid, 0);
      chk($sformatf("t5_dbg_rvalid_%0d", i), dbg_rvalid, 0);
      chk($sformatf("t5_mem_en_%0d", i), mem_en, 0);
      chk($sformatf("t5_mem_addr_%0d", i), mem_addr, 0);
      chk($sformatf("t5_mem_wdata_%0d", i), mem_wdata, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
